// File: rtl/dpram_arbiter.sv
// Two-requester front end for a true dual-port RAM. Same-address accesses involving a
// write are serialised under a toggling priority; all other traffic goes through in parallel.
module dpram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          wr_a,
    input  logic          wr_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic          ram_we_a,
    output logic          ram_re_a,
    output logic          ram_we_b,
    output logic          ram_re_b,
    output logic [AW-1:0] ram_add_a,
    output logic [AW-1:0] ram_add_b,
    output logic [DW-1:0] ram_data_a,
    output logic [DW-1:0] ram_data_b,
    input  logic [DW-1:0] ram_out_a,
    input  logic [DW-1:0] ram_out_b,
    output logic [CW-1:0] conflict_cnt,
    output logic          pri_b
);

    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_state_t;

    pri_state_t    state_q;
    pri_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rvalid_a_q;
    logic          rvalid_a_d;
    logic          rvalid_b_q;
    logic          rvalid_b_d;
    logic          conflict_s;
    logic          gnt_a_s;
    logic          gnt_b_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CW'(1);
        end
    endfunction

    // Conflict detection and grant generation; reset holds every grant low.
    always_comb begin
        conflict_s = req_a & req_b & (addr_a == addr_b) & (wr_a | wr_b);
        gnt_a_s    = 1'b0;
        gnt_b_s    = 1'b0;
        if (!rst) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else if (conflict_s) begin
            case (state_q)
                PRI_A:   gnt_a_s = 1'b1;
                PRI_B:   gnt_b_s = 1'b1;
                default: gnt_a_s = 1'b1;
            endcase
        end else begin
            gnt_a_s = req_a;
            gnt_b_s = req_b;
        end
    end

    // Priority hands over to the loser of each conflict; counter saturates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rvalid_a_d = gnt_a_s & ~wr_a;
        rvalid_b_d = gnt_b_s & ~wr_b;
        if (rst && conflict_s) begin
            cnt_d = sat_inc(cnt_q);
            case (state_q)
                PRI_A:   state_d = PRI_B;
                PRI_B:   state_d = PRI_A;
                default: state_d = PRI_A;
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // State registers; reset also discards any read return still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PRI_A;
            cnt_q      <= {CW{1'b0}};
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign gnt_a        = gnt_a_s;
    assign gnt_b        = gnt_b_s;
    assign ram_we_a     = req_a & gnt_a_s & wr_a;
    assign ram_re_a     = req_a & gnt_a_s & ~wr_a;
    assign ram_we_b     = req_b & gnt_b_s & wr_b;
    assign ram_re_b     = req_b & gnt_b_s & ~wr_b;
    assign ram_add_a    = addr_a;
    assign ram_add_b    = addr_b;
    assign ram_data_a   = wdata_a;
    assign ram_data_b   = wdata_b;
    assign rvalid_a     = rvalid_a_q;
    assign rvalid_b     = rvalid_b_q;
    assign rdata_a      = rvalid_a_q ? ram_out_a : {DW{1'b0}};
    assign rdata_b      = rvalid_b_q ? ram_out_b : {DW{1'b0}};
    assign conflict_cnt = cnt_q;
    assign pri_b        = (state_q == PRI_B);

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration rules and a shadow memory.
module tb_dpram_arbiter;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, wr_a, wr_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_we_a, ram_re_a, ram_we_b, ram_re_b;
    logic [AW-1:0] ram_add_a, ram_add_b;
    logic [DW-1:0] ram_data_a, ram_data_b;
    logic [DW-1:0] ram_out_a, ram_out_b;
    logic [CW-1:0] conflict_cnt;
    logic          pri_b;

    dpram_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .ram_we_a(ram_we_a), .ram_re_a(ram_re_a), .ram_we_b(ram_we_b), .ram_re_b(ram_re_b),
        .ram_add_a(ram_add_a), .ram_add_b(ram_add_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_out_a(ram_out_a), .ram_out_b(ram_out_b),
        .conflict_cnt(conflict_cnt), .pri_b(pri_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM behind the arbiter: one-cycle read latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_add_a] <= ram_data_a;
        if (ram_we_b) mem[ram_add_b] <= ram_data_b;
        if (ram_re_a) ram_out_a <= mem[ram_add_a];
        if (ram_re_b) ram_out_b <= mem[ram_add_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DW-1:0] shadow [16];
    bit            m_pri;
    int            m_cnt;
    bit            m_rv_a, m_rv_b;
    logic [DW-1:0] m_rd_a, m_rd_b;
    bit            mg_a, mg_b;

    // Observed values from the last cycle, for directed checks
    logic          obs_gnt_a, obs_gnt_b, obs_rv_a, obs_rv_b, obs_pri;
    logic [DW-1:0] obs_rd_a, obs_rd_b;
    logic [CW-1:0] obs_cnt;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic rs,
                         input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        bit conf, ega, egb;
        @(negedge clk);
        rst = rs; req_a = ra; wr_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; wr_b = wb; addr_b = ab; wdata_b = db;
        if (!rs) begin
            m_pri = 1'b0; m_cnt = 0; m_rv_a = 1'b0; m_rv_b = 1'b0;
        end
        #1;
        conf = rs && ra && rb && (aa == ab) && (wa || wb);
        ega  = rs && ra && (!conf || !m_pri);
        egb  = rs && rb && (!conf || m_pri);
        check_value("gnt_a", 32'(gnt_a), 32'(ega));
        check_value("gnt_b", 32'(gnt_b), 32'(egb));
        check_value("ram_we_a", 32'(ram_we_a), 32'(ega && wa));
        check_value("ram_re_a", 32'(ram_re_a), 32'(ega && !wa));
        check_value("ram_we_b", 32'(ram_we_b), 32'(egb && wb));
        check_value("ram_re_b", 32'(ram_re_b), 32'(egb && !wb));
        check_value("ram_add_a", 32'(ram_add_a), 32'(aa));
        check_value("ram_add_b", 32'(ram_add_b), 32'(ab));
        check_value("ram_data_a", 32'(ram_data_a), 32'(da));
        check_value("ram_data_b", 32'(ram_data_b), 32'(db));
        check_value("rvalid_a", 32'(rvalid_a), 32'(m_rv_a));
        check_value("rvalid_b", 32'(rvalid_b), 32'(m_rv_b));
        check_value("rdata_a", 32'(rdata_a), m_rv_a ? 32'(m_rd_a) : 32'd0);
        check_value("rdata_b", 32'(rdata_b), m_rv_b ? 32'(m_rd_b) : 32'd0);
        check_value("pri_b", 32'(pri_b), 32'(m_pri));
        check_value("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        obs_gnt_a = gnt_a; obs_gnt_b = gnt_b; obs_rv_a = rvalid_a; obs_rv_b = rvalid_b;
        obs_rd_a = rdata_a; obs_rd_b = rdata_b; obs_cnt = conflict_cnt; obs_pri = pri_b;
        mg_a = ega; mg_b = egb;
        // Effect of the coming rising edge
        if (rs) begin
            m_rv_a = ega && !wa;
            m_rv_b = egb && !wb;
            m_rd_a = shadow[aa];
            m_rd_b = shadow[ab];
            if (ega && wa) shadow[aa] = da;
            if (egb && wb) shadow[ab] = db;
            if (conf) begin
                m_pri = !m_pri;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    endtask

    task automatic idle(input logic rs);
        cycle(rs, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    initial begin
        int rv_cnt_a, rv_cnt_b, rv_after;
        bit pa_req, pa_wr, pb_req, pb_wr;
        logic [AW-1:0] pa_addr, pb_addr;
        logic [DW-1:0] pa_data, pb_data;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'h00; shadow[i] = 8'h00;
        end
        ram_out_a = 8'h00; ram_out_b = 8'h00;
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        addr_a = 4'd0; addr_b = 4'd0; wdata_a = 8'h00; wdata_b = 8'h00;
        m_pri = 1'b0; m_cnt = 0; m_rv_a = 1'b0; m_rv_b = 1'b0; m_rd_a = 8'h00; m_rd_b = 8'h00;
        mg_a = 1'b0; mg_b = 1'b0;

        // Reset held with random traffic
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                        1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));

        // Parallel writes then cross reads
        cycle(1'b1, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b1, 4'd7, 8'h3C);
        check_value("par_wr_gnt", 32'({obs_gnt_a, obs_gnt_b}), 32'd3);
        cycle(1'b1, 1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
        check_value("par_rd_gnt", 32'({obs_gnt_a, obs_gnt_b}), 32'd3);
        idle(1'b1);
        check_value("par_rdata_a", 32'(obs_rd_a), 32'h3C);
        check_value("par_rdata_b", 32'(obs_rd_b), 32'hA5);

        // Write-write conflict at 5
        cycle(1'b1, 1'b1, 1'b1, 4'd5, 8'h11, 1'b1, 1'b1, 4'd5, 8'h22);
        check_value("ww_gnt1", 32'({obs_gnt_a, obs_gnt_b}), 32'd2);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd5, 8'h22);
        check_value("ww_pri", 32'(obs_pri), 32'd1);
        check_value("ww_gnt2", 32'(obs_gnt_b), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(1'b1);
        check_value("ww_rdata", 32'(obs_rd_a), 32'h22);
        check_value("ww_cnt", 32'(obs_cnt), 32'd1);

        // Read-write conflict at 9 with B holding priority
        cycle(1'b1, 1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 1'b1, 4'd9, 8'h77);
        check_value("rw_gnt1", 32'({obs_gnt_a, obs_gnt_b}), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        check_value("rw_pri", 32'(obs_pri), 32'd0);
        check_value("rw_gnt2", 32'(obs_gnt_a), 32'd1);
        idle(1'b1);
        check_value("rw_rdata", 32'(obs_rd_a), 32'h77);

        // Read-read same address, 20 cycles
        rv_cnt_a = 0; rv_cnt_b = 0;
        for (int i = 0; i < 21; i++) begin
            if (i < 20) cycle(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
            else idle(1'b1);
            rv_cnt_a += int'(obs_rv_a); rv_cnt_b += int'(obs_rv_b);
        end
        check_value("rr_pulses_a", 32'(rv_cnt_a), 32'd20);
        check_value("rr_pulses_b", 32'(rv_cnt_b), 32'd20);
        check_value("rr_cnt", 32'(obs_cnt), 32'd2);

        // Saturation after five conflicts, then reset in the middle of a read
        idle(1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 1'b1, 4'd1, 8'(i), 1'b1, 1'b1, 4'd1, 8'(i + 16));
        idle(1'b1);
        check_value("sat_cnt", 32'(obs_cnt), 32'd3);
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(1'b0);
        check_value("rst_mid_rv", 32'(obs_rv_a), 32'd0);
        rv_after = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            rv_after += int'(obs_rv_a);
        end
        check_value("rst_no_rv", 32'(rv_after), 32'd0);

        // Random traffic obeying the hold-until-grant handshake
        pa_req = 1'b0; pb_req = 1'b0; pa_wr = 1'b0; pb_wr = 1'b0;
        pa_addr = 4'd0; pb_addr = 4'd0; pa_data = 8'h00; pb_data = 8'h00;
        for (int i = 0; i < 800; i++) begin
            logic rs;
            rs = ($urandom_range(0, 39) != 0);
            if (!(pa_req && !mg_a)) begin
                pa_req = ($urandom_range(0, 9) < 7); pa_wr = 1'($urandom);
                pa_addr = 4'($urandom_range(0, 3)); pa_data = 8'($urandom);
            end
            if (!(pb_req && !mg_b)) begin
                pb_req = ($urandom_range(0, 9) < 7); pb_wr = 1'($urandom);
                pb_addr = 4'($urandom_range(0, 3)); pb_data = 8'($urandom);
            end
            cycle(rs, pa_req, pa_wr, pa_addr, pa_data, pb_req, pb_wr, pb_addr, pb_data);
        end
        idle(1'b1);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 4, address width; DW, default 8, data width; CW, default 8, conflict counter width.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; SHALL clear all state immediately on assertion, independent of clk.
REQ-004 req_a / req_b  input  1  requester A / B transfer request.
REQ-005 wr_a / wr_b  input  1  1 = write, 0 = read; valid while req is high.
REQ-006 addr_a / addr_b  input  AW  requester address.
REQ-007 wdata_a / wdata_b  input  DW  requester write data.
REQ-008 gnt_a / gnt_b  output  1  transfer accepted this cycle (combinational).
REQ-009 rdata_a / rdata_b  output  DW  read data, valid only while rvalid is high.
REQ-010 rvalid_a / rvalid_b  output  1  registered read-return strobe.
REQ-011 ram_we_a, ram_re_a, ram_we_b, ram_re_b  output  1  RAM port write/read enables.
REQ-012 ram_add_a / ram_add_b  output  AW  RAM port addresses; ram_data_a / ram_data_b  output  DW  RAM write data.
REQ-013 ram_out_a / ram_out_b  input  DW  RAM read data, updated one clock after a sampled ram_re.
REQ-014 conflict_cnt  output  CW  count of serialized conflicts, saturating.
REQ-015 pri_b  output  1  current priority holder (0 = A, 1 = B).

Function
REQ-016 Handshake: requester SHALL hold req/wr/addr/wdata stable until gnt; transfer completes on the rising edge where req&gnt=1.
REQ-017 Conflict SHALL be defined as req_a & req_b & (addr_a==addr_b) & (wr_a|wr_b).
REQ-018 No conflict: gnt_a=req_a, gnt_b=req_b in the same cycle (both ports served concurrently, including read-read to the same address).
REQ-019 Conflict: only the priority holder SHALL be granted; the other's gnt SHALL be 0 that cycle.
REQ-020 Priority FSM states PRI_A (reset) and PRI_B; on a clock edge with a conflict the state SHALL move to the non-granted side; otherwise the state SHALL hold.
REQ-021 Port A mapping: ram_we_a = req_a&gnt_a&wr_a; ram_re_a = req_a&gnt_a&~wr_a; ram_add_a = addr_a; ram_data_a = wdata_a; port B mirrors this; with no grant, enables SHALL be 0.
REQ-022 rvalid_x SHALL be 1 exactly one cycle after the edge completing a read on port x; rdata_x = ram_out_x while rvalid_x; otherwise rdata_x = 0.
REQ-023 Back-to-back reads SHALL produce back-to-back rvalid pulses, one per granted read, in order.
REQ-024 conflict_cnt SHALL increment by 1 on each edge with a conflict, saturating at 2^CW-1 (no wrap).
REQ-025 A deasserted req with no gnt SHALL leave the FSM and counters unchanged; a write then a read to the same address on consecutive grants SHALL return the new data.

Reset
REQ-026 While rst=0: gnt_*=0, ram_we_*=0, ram_re_*=0, rvalid_*=0, rdata_*=0, conflict_cnt=0, pri_b=0 (PRI_A); address/data outputs SHALL follow inputs.
REQ-027 Reset asserted mid-read SHALL drop the pending rvalid; no rvalid SHALL be issued after deassertion for reads accepted before reset.
REQ-028 The first edge after rst deasserts SHALL evaluate requests normally.

Verification
REQ-029 Reset: rst=0 for 5 cycles with random requests -> all strobes 0, conflict_cnt=0, pri_b=0.
REQ-030 Parallel: A writes 8'hA5 @3 while B writes 8'h3C @7 -> both gnt same cycle; A reads @7 and B reads @3 -> rvalid both next cycle, rdata_a=8'h3C, rdata_b=8'hA5.
REQ-031 Write-write conflict @5: A=8'h11, B=8'h22 held -> cycle 1 gnt_a only, pri_b becomes 1; cycle 2 gnt_b; read @5 returns 8'h22; conflict_cnt=1.
REQ-032 Read-write conflict @9 with pri_b=1 -> B written first, A's read then returns B's data; pri_b returns to 0.
REQ-033 Read-read same address @2, 20 consecutive cycles -> both granted every cycle, conflict_cnt unchanged, 20 rvalid pulses per port.
REQ-034 Saturation with CW=2: 5 conflicts -> conflict_cnt stops at 3; rst=0 mid-read -> no rvalid after release.
